// File: rtl/axicb_grant_lock.sv
// Burst-level grant lock behind the crossbar round-robin arbiter: holds the chosen
// master's select from its first beat until its xLAST beat and forwards its handshake.
module axicb_grant_lock #(
  parameter int unsigned REQ_NB    = 4,
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              srst,
  input  logic [REQ_NB-1:0] in_valid,
  input  logic [REQ_NB-1:0] in_last,
  output logic [REQ_NB-1:0] in_ready,
  output logic              rr_en,
  output logic [REQ_NB-1:0] rr_req,
  input  logic [REQ_NB-1:0] rr_grant,
  output logic [REQ_NB-1:0] sel,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              len_err
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [REQ_NB-1:0] r_grant_q;
  logic [REQ_NB-1:0] w_grant_nxt;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              r_len_err;
  logic              w_err_nxt;
  logic              w_beat;

  // Zero-latency handshake path: the arbiter grant is used directly until the lock is taken.
  assign sel       = (r_state == ST_LOCKED) ? r_grant_q : rr_grant;
  assign out_valid = |(in_valid & sel);
  assign out_last  = |(in_last & sel);
  assign in_ready  = sel & {REQ_NB{out_ready}};
  assign w_beat    = out_valid & out_ready;
  assign busy      = (r_state == ST_LOCKED);
  assign len_err   = r_len_err;
  assign w_cnt_inc = (r_beat_cnt == CNT_MAX) ? CNT_MAX : r_beat_cnt + CNT_W'(1);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ST_IDLE;
      r_grant_q  <= '0;
      r_beat_cnt <= '0;
      r_len_err  <= 1'b0;
    end else if (srst) begin
      r_state    <= ST_IDLE;
      r_grant_q  <= '0;
      r_beat_cnt <= '0;
      r_len_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant_q  <= w_grant_nxt;
      r_beat_cnt <= w_cnt_nxt;
      r_len_err  <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_q;
    w_cnt_nxt   = r_beat_cnt;
    w_err_nxt   = r_len_err;
    rr_req      = '0;
    rr_en       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        rr_req = in_valid;
        rr_en  = |in_valid;
        // Single-beat bursts never lock; anything else (including a stalled slave) does.
        if (|in_valid && !(w_beat && out_last)) begin
          w_state_nxt = ST_LOCKED;
          w_grant_nxt = rr_grant;
          w_cnt_nxt   = w_beat ? CNT_W'(1) : '0;
          if (w_beat && (CNT_MAX == CNT_W'(1))) w_err_nxt = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (w_beat && out_last) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
        end else if (w_beat) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CNT_MAX) w_err_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
